isp_wb: RTL and testbench
=========================

# isp_wb

White-balance gain stage for the raw Bayer pipeline, sitting directly downstream of black-level correction and upstream of demosaic. Applies a per-channel (B/Gb/Gr/R) unsigned Q4.4 gain to each raw pixel with rounding and saturation, 2-cycle pipelined. Gains are double-buffered and take effect only at frame boundaries. Also accumulates per-frame, pre-gain channel sums for AWB firmware.

## Interface
- BITS, 8, raw pixel width
- WIDTH, 1280, active pixels per line (sizes stat accumulators)
- HEIGHT, 960, active lines per frame (sizes stat accumulators)
- BAYER, 0, CFA phase: 0 BGGR, 1 GBRG, 2 GRBG, 3 RGGB
- STAT_BITS, BITS+20, width of each stat sum
- pclk  in  1  pixel clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- gain_b / gain_gb / gain_gr / gain_r  in  8 each  shadow gains, Q4.4 (0x10 = 1.0)
- in_href  in  1  line valid
- in_vsync  in  1  frame sync, active-high during vertical blanking
- in_raw  in  BITS  raw pixel (post-BLC)
- out_href  out  1  in_href delayed 2 cycles
- out_vsync  out  1  in_vsync delayed 2 cycles
- out_raw  out  BITS  gained pixel
- sum_b / sum_g / sum_r  out  STAT_BITS each  previous-frame channel sums (sum_g = Gb+Gr)
- stat_valid  out  1  one-cycle pulse when sums update

## Operation
- Bayer phase: odd_pix clears while in_href=0 and toggles each href cycle. odd_line clears while in_vsync=1 and toggles on each href falling edge. Phase code {odd_line, odd_pix} is XORed with BAYER[1:0]: 00=B, 01=Gb, 10=Gr, 11=R.
- Gain shadowing: active gain registers load from the gain_* inputs on the cycle in_vsync rises (0→1). Mid-frame input changes have no effect until the next rise. Reset value of every active gain is 0x10.
- Arithmetic: product = in_raw × active_gain (BITS+8 bits); result = (product + 8) >> 4, saturated to 2^BITS−1. Gain 0 yields 0.
- Stats:
  - A pixel is counted when in_href=1 and in_vsync=0. Accumulation uses in_raw (pre-gain), steered by phase code.
  - Each accumulator saturates at 2^STAT_BITS−1; no wrap.
  - On a vsync rise: the accumulators copy to sum_* and clear in the same cycle. stat_valid pulses for 1 cycle only if at least one pixel was counted since the previous rise (frame_seen flag), then frame_seen clears.
  - No stat_valid pulse on the first vsync after reset.
- Reset, synchronous, mid-operation: all outputs go to 0 (out_href, out_vsync, out_raw, sum_*, stat_valid). Phase, accumulators and frame_seen clear. Active gains return to 0x10. The partial frame is discarded.

## Timing
- Stage 1: register phase-selected gain and product. Stage 2: round, saturate, register out_raw.
- Latency from in_raw to out_raw is exactly 2 cycles. out_href and out_vsync are delayed by the same 2 stages, so they stay aligned with out_raw.
- out_raw is 0 when the corresponding href is 0 (zero-gated in stage 2).
- stat_valid and sum_* update 1 cycle after the in_vsync rise is sampled.
- Gain switch boundary: the first pixel of the next frame uses the new gains. The last pixel before the rise still in flight uses the old gains, because gains are captured in stage 1.

## Structure
- Shared package isp_pkg holds:
  - BAYER_BGGR/GBRG/GRBG/RGGB constants
  - 2-bit colour codes CH_B/CH_GB/CH_GR/CH_R
  - GAIN_ONE = 8'h10 and GAIN_FRAC = 4
- Sub-module isp_bayer_phase (pclk, rst_n, href, vsync, BAYER → 2-bit colour code). It is reusable by BLC and later stages.
- Accumulators and the gain pipeline stay inline in isp_wb.

## Test plan
- Unity gains, BITS=8, ramp 0..255 → out_raw equals in_raw exactly 2 cycles later; out_href/out_vsync aligned.
- BGGR, gain_r=0x20, gain_b=0x18: R pixel 100→200, R pixel 200→255 (saturate), B pixel 11→17, Gb pixel at gain 0x10 passes unchanged.
- Write gain_gr=0x08 mid-frame → the rest of that frame is unchanged. After the vsync rise, Gr pixel 50→25.
- WIDTH=4, HEIGHT=2, BGGR, constant B=10, G=20, R=30 → no stat_valid at first vsync after reset. At the following vsync rise: sum_b=20, sum_g=80, sum_r=60, stat_valid high for 1 cycle.
- BAYER=3 (RGGB), gain_r=0x20, other gains 0x10: first pixel of line 0 (value 40) → 80; second pixel (value 40) → 40.
- Assert rst_n=0 for one cycle mid-line → next cycle all outputs 0 and active gains 0x10. The following frame produces no stat_valid at its opening vsync rise.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared definitions for the raw Bayer pipeline stages: CFA phases, colour codes, gain format.
package isp_pkg;

   localparam logic [1:0] BAYER_BGGR = 2'd0;
   localparam logic [1:0] BAYER_GBRG = 2'd1;
   localparam logic [1:0] BAYER_GRBG = 2'd2;
   localparam logic [1:0] BAYER_RGGB = 2'd3;

   typedef enum logic [1:0] {
      CH_B  = 2'b00,
      CH_GB = 2'b01,
      CH_GR = 2'b10,
      CH_R  = 2'b11
   } ch_t;

   localparam logic [7:0] GAIN_ONE  = 8'h10;
   localparam int         GAIN_FRAC = 4;

   function automatic ch_t bayer_ch(input logic [1:0] phase, input logic [1:0] bayer);
      return ch_t'(phase ^ bayer);
   endfunction

endpackage

// File: rtl/isp_wb_if.sv
// Raw video stream into and out of a pipeline stage (href/vsync framing plus pixel).
interface isp_wb_if #(
   parameter int BITS = 8
);
   logic            in_href;
   logic            in_vsync;
   logic [BITS-1:0] in_raw;
   logic            out_href;
   logic            out_vsync;
   logic [BITS-1:0] out_raw;

   modport master (
      output in_href, in_vsync, in_raw,
      input  out_href, out_vsync, out_raw
   );

   modport slave (
      input  in_href, in_vsync, in_raw,
      output out_href, out_vsync, out_raw
   );
endinterface

// File: rtl/isp_bayer_phase.sv
// Tracks pixel/line parity from href/vsync and maps it to the colour of the current pixel.
module isp_bayer_phase
   import isp_pkg::*;
#(
   parameter logic [1:0] BAYER = BAYER_BGGR
) (
   input  logic pclk,
   input  logic rst_n,
   input  logic href,
   input  logic vsync,
   output ch_t  ch
);

   logic odd_pix;
   logic odd_line;
   logic href_d;

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         odd_pix  <= 1'b0;
         odd_line <= 1'b0;
         href_d   <= 1'b0;
      end else begin
         href_d  <= href;
         odd_pix <= href ? ~odd_pix : 1'b0;
         if (vsync)
            odd_line <= 1'b0;
         else if (href_d && !href)
            odd_line <= ~odd_line;
      end
   end

   assign ch = bayer_ch({odd_line, odd_pix}, BAYER);

endmodule

// File: rtl/isp_wb.sv
// White-balance gain stage: per-channel Q4.4 gain with rounding/saturation over two pipeline
// stages, frame-synchronous gain shadowing, and pre-gain per-frame channel sums for AWB.
module isp_wb
   import isp_pkg::*;
#(
   parameter int BITS      = 8,
   parameter int WIDTH     = 1280,
   parameter int HEIGHT    = 960,
   parameter int BAYER     = 0,
   parameter int STAT_BITS = BITS + 20
) (
   input  logic                 pclk,
   input  logic                 rst_n,
   input  logic [7:0]           gain_b,
   input  logic [7:0]           gain_gb,
   input  logic [7:0]           gain_gr,
   input  logic [7:0]           gain_r,
   isp_wb_if.slave              vid,
   output logic [STAT_BITS-1:0] sum_b,
   output logic [STAT_BITS-1:0] sum_g,
   output logic [STAT_BITS-1:0] sum_r,
   output logic                 stat_valid
);

   localparam int PW = BITS + 8;

   if ((WIDTH < 1) || (HEIGHT < 1)) begin : g_bad_frame_size
      $error("isp_wb: WIDTH and HEIGHT must be nonzero");
   end

   ch_t                 ch;
   logic                vsync_d;
   logic                vs_rise;
   logic                count;
   logic [7:0]          act_b, act_gb, act_gr, act_r;
   logic [7:0]          gain_sel;
   logic [PW-1:0]       prod_q;
   logic                href1, vsync1;
   logic [PW:0]         scaled;
   logic [BITS-1:0]     gained;
   logic [STAT_BITS-1:0] acc_b, acc_g, acc_r;
   logic                frame_seen;
   logic                armed;

   isp_bayer_phase #(.BAYER(2'(BAYER))) u_phase (
      .pclk  (pclk),
      .rst_n (rst_n),
      .href  (vid.in_href),
      .vsync (vid.in_vsync),
      .ch    (ch)
   );

   function automatic logic [STAT_BITS-1:0] sat_add(input logic [STAT_BITS-1:0] acc,
                                                    input logic [BITS-1:0] raw);
      logic [STAT_BITS:0] s;
      s = {1'b0, acc} + (STAT_BITS+1)'(raw);
      return s[STAT_BITS] ? '1 : s[STAT_BITS-1:0];
   endfunction

   assign vs_rise = vid.in_vsync && !vsync_d;
   assign count   = vid.in_href && !vid.in_vsync;

   always_comb begin
      gain_sel = act_b;
      case (ch)
         CH_B:    gain_sel = act_b;
         CH_GB:   gain_sel = act_gb;
         CH_GR:   gain_sel = act_gr;
         CH_R:    gain_sel = act_r;
         default: gain_sel = act_b;
      endcase
   end

   // Round half up at the Q4.4 binary point, then clamp to full scale.
   assign scaled = ({1'b0, prod_q} + (PW+1)'(1 << (GAIN_FRAC-1))) >> GAIN_FRAC;
   assign gained = (|scaled[PW:BITS]) ? '1 : scaled[BITS-1:0];

   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         vsync_d       <= 1'b0;
         act_b         <= GAIN_ONE;
         act_gb        <= GAIN_ONE;
         act_gr        <= GAIN_ONE;
         act_r         <= GAIN_ONE;
         prod_q        <= '0;
         href1         <= 1'b0;
         vsync1        <= 1'b0;
         vid.out_href  <= 1'b0;
         vid.out_vsync <= 1'b0;
         vid.out_raw   <= '0;
         acc_b         <= '0;
         acc_g         <= '0;
         acc_r         <= '0;
         sum_b         <= '0;
         sum_g         <= '0;
         sum_r         <= '0;
         stat_valid    <= 1'b0;
         frame_seen    <= 1'b0;
         armed         <= 1'b0;
      end else begin
         vsync_d    <= vid.in_vsync;
         stat_valid <= 1'b0;

         // armed keeps the frame cut short by a reset from ever being reported.
         if (vs_rise) begin
            act_b      <= gain_b;
            act_gb     <= gain_gb;
            act_gr     <= gain_gr;
            act_r      <= gain_r;
            sum_b      <= acc_b;
            sum_g      <= acc_g;
            sum_r      <= acc_r;
            acc_b      <= '0;
            acc_g      <= '0;
            acc_r      <= '0;
            stat_valid <= frame_seen && armed;
            frame_seen <= 1'b0;
            armed      <= 1'b1;
         end else if (count) begin
            frame_seen <= 1'b1;
            case (ch)
               CH_B:         acc_b <= sat_add(acc_b, vid.in_raw);
               CH_GB, CH_GR: acc_g <= sat_add(acc_g, vid.in_raw);
               CH_R:         acc_r <= sat_add(acc_r, vid.in_raw);
               default:      acc_b <= acc_b;
            endcase
         end

         href1  <= vid.in_href;
         vsync1 <= vid.in_vsync;
         prod_q <= PW'(vid.in_raw) * PW'(gain_sel);

         vid.out_href  <= href1;
         vid.out_vsync <= vsync1;
         vid.out_raw   <= href1 ? gained : '0;
      end
   end

endmodule

// File: tb/tb_isp_wb.sv
// Directed bench for isp_wb: a BGGR and an RGGB instance share one stimulus stream.
module tb_isp_wb;
   import isp_pkg::*;

   logic       pclk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] gain_b  = 8'h10;
   logic [7:0] gain_gb = 8'h10;
   logic [7:0] gain_gr = 8'h10;
   logic [7:0] gain_r  = 8'h10;

   logic [27:0] sb0, sg0, sr0, sb3, sg3, sr3;
   logic        sv0, sv3;

   int n_assert = 0;
   int n_fail   = 0;

   logic       ph, pv;
   logic [7:0] pe0, pe3;

   always #5 pclk = ~pclk;

   isp_wb_if #(.BITS(8)) vid0 ();
   isp_wb_if #(.BITS(8)) vid3 ();

   isp_wb #(.BITS(8), .WIDTH(4), .HEIGHT(2), .BAYER(0), .STAT_BITS(28)) dut0 (
      .pclk(pclk), .rst_n(rst_n),
      .gain_b(gain_b), .gain_gb(gain_gb), .gain_gr(gain_gr), .gain_r(gain_r),
      .vid(vid0),
      .sum_b(sb0), .sum_g(sg0), .sum_r(sr0), .stat_valid(sv0)
   );

   isp_wb #(.BITS(8), .WIDTH(4), .HEIGHT(2), .BAYER(int'(BAYER_RGGB)), .STAT_BITS(28)) dut3 (
      .pclk(pclk), .rst_n(rst_n),
      .gain_b(gain_b), .gain_gb(gain_gb), .gain_gr(gain_gr), .gain_r(gain_r),
      .vid(vid3),
      .sum_b(sb3), .sum_g(sg3), .sum_r(sr3), .stat_valid(sv3)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge pclk);
      #1;
   endtask

   task automatic drive(input logic h, input logic v, input logic [7:0] raw);
      vid0.in_href  = h;
      vid0.in_vsync = v;
      vid0.in_raw   = raw;
      vid3.in_href  = h;
      vid3.in_vsync = v;
      vid3.in_raw   = raw;
   endtask

   // Outputs seen after this step belong to the pixel of the previous step.
   task automatic step(input logic h, input logic v, input logic [7:0] raw,
                       input logic [7:0] e0, input logic [7:0] e3, input logic sv,
                       input string tag);
      drive(h, v, raw);
      cyc();
      check({tag, ":out_href"},  64'(vid0.out_href),  64'(ph));
      check({tag, ":out_vsync"}, 64'(vid0.out_vsync), 64'(pv));
      check({tag, ":raw_bggr"},  64'(vid0.out_raw),   64'(pe0));
      check({tag, ":raw_rggb"},  64'(vid3.out_raw),   64'(pe3));
      check({tag, ":stat_valid"}, 64'(sv0), 64'(sv));
      ph  = h;
      pv  = v;
      pe0 = h ? e0 : 8'd0;
      pe3 = h ? e3 : 8'd0;
   endtask

   task automatic gap(input string tag);
      step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, tag);
   endtask

   task automatic check_sums(input string tag,
                             input logic [27:0] b0, input logic [27:0] g0, input logic [27:0] r0,
                             input logic [27:0] b3, input logic [27:0] g3, input logic [27:0] r3);
      check({tag, ":sum_b_bggr"}, 64'(sb0), 64'(b0));
      check({tag, ":sum_g_bggr"}, 64'(sg0), 64'(g0));
      check({tag, ":sum_r_bggr"}, 64'(sr0), 64'(r0));
      check({tag, ":sum_b_rggb"}, 64'(sb3), 64'(b3));
      check({tag, ":sum_g_rggb"}, 64'(sg3), 64'(g3));
      check({tag, ":sum_r_rggb"}, 64'(sr3), 64'(r3));
      check({tag, ":stat_valid_rggb"}, 64'(sv3), 64'(sv0));
   endtask

   task automatic check_zero(input string tag);
      check({tag, ":out_href"},   64'(vid0.out_href),  64'd0);
      check({tag, ":out_vsync"},  64'(vid0.out_vsync), 64'd0);
      check({tag, ":out_raw"},    64'(vid0.out_raw),   64'd0);
      check({tag, ":sum_b"},      64'(sb0),            64'd0);
      check({tag, ":sum_g"},      64'(sg0),            64'd0);
      check({tag, ":sum_r"},      64'(sr0),            64'd0);
      check({tag, ":stat_valid"}, 64'(sv0),            64'd0);
   endtask

   initial begin
      ph = 1'b0; pv = 1'b0; pe0 = 8'd0; pe3 = 8'd0;
      drive(1'b0, 1'b0, 8'd0);
      rst_n = 1'b0;
      cyc();
      cyc();
      check_zero("reset");
      rst_n = 1'b1;

      // Unity gains: ramp passes through unchanged on both phases
      for (int i = 0; i < 256; i++)
         step(1'b1, 1'b0, 8'(i), 8'(i), 8'(i), 1'b0, "ramp");
      gap("ramp_gap0");
      gap("ramp_gap1");

      // First vsync after reset: pixels were counted but no pulse is allowed
      gain_b = 8'h18;
      gain_r = 8'h20;
      step(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0, "vs1_rise");
      step(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0, "vs1_hold");
      gap("vs1_fall");

      // Frame B: BGGR line0 = B Gb B Gb, RGGB line0 = R Gr R Gr
      step(1'b1, 1'b0, 8'd40,  8'd60,  8'd80,  1'b0, "fb_l0p0");
      step(1'b1, 1'b0, 8'd40,  8'd40,  8'd40,  1'b0, "fb_l0p1");
      step(1'b1, 1'b0, 8'd11,  8'd17,  8'd22,  1'b0, "fb_l0p2");
      step(1'b1, 1'b0, 8'd77,  8'd77,  8'd77,  1'b0, "fb_l0p3");
      gap("fb_gap0");
      gain_gr = 8'h08;
      gap("fb_gap1");
      // line1: BGGR = Gr R Gr R, RGGB = Gb B Gb B; Gr gain change not yet active
      step(1'b1, 1'b0, 8'd50,  8'd50,  8'd50,  1'b0, "fb_l1p0");
      step(1'b1, 1'b0, 8'd100, 8'd200, 8'd150, 1'b0, "fb_l1p1");
      step(1'b1, 1'b0, 8'd50,  8'd50,  8'd50,  1'b0, "fb_l1p2");
      step(1'b1, 1'b0, 8'd200, 8'd255, 8'd255, 1'b0, "fb_l1p3");
      gap("fb_gap2");
      gap("fb_gap3");
      step(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b1, "fb_rise");
      check_sums("fb", 28'd51, 28'd217, 28'd300, 28'd300, 28'd217, 28'd51);
      step(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0, "fb_hold");
      gap("fb_fall");

      // Frame C: constant B=10 G=20 R=30 over 4x2, gr gain now 0x08
      step(1'b1, 1'b0, 8'd10, 8'd15, 8'd20, 1'b0, "fc_l0p0");
      step(1'b1, 1'b0, 8'd20, 8'd20, 8'd10, 1'b0, "fc_l0p1");
      step(1'b1, 1'b0, 8'd10, 8'd15, 8'd20, 1'b0, "fc_l0p2");
      step(1'b1, 1'b0, 8'd20, 8'd20, 8'd10, 1'b0, "fc_l0p3");
      gap("fc_gap0");
      gap("fc_gap1");
      step(1'b1, 1'b0, 8'd20, 8'd10, 8'd20, 1'b0, "fc_l1p0");
      step(1'b1, 1'b0, 8'd30, 8'd60, 8'd45, 1'b0, "fc_l1p1");
      step(1'b1, 1'b0, 8'd20, 8'd10, 8'd20, 1'b0, "fc_l1p2");
      step(1'b1, 1'b0, 8'd30, 8'd60, 8'd45, 1'b0, "fc_l1p3");
      gap("fc_gap2");
      gap("fc_gap3");
      step(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b1, "fc_rise");
      check_sums("fc", 28'd20, 28'd80, 28'd60, 28'd60, 28'd80, 28'd20);
      step(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0, "fc_hold");
      gap("fc_fall");

      // Frame D: RGGB R 40 -> 80, Gr 50 -> 25; then a one-cycle reset mid-line
      step(1'b1, 1'b0, 8'd40, 8'd60, 8'd80, 1'b0, "fd_l0p0");
      step(1'b1, 1'b0, 8'd50, 8'd50, 8'd25, 1'b0, "fd_l0p1");
      drive(1'b1, 1'b0, 8'd99);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      check_zero("mid_reset");
      ph = 1'b0; pv = 1'b0; pe0 = 8'd0; pe3 = 8'd0;
      // Active gains back to unity although the gain inputs still hold other values
      step(1'b1, 1'b0, 8'd100, 8'd100, 8'd100, 1'b0, "rst_p0");
      step(1'b1, 1'b0, 8'd100, 8'd100, 8'd100, 1'b0, "rst_p1");
      gap("rst_gap0");
      gap("rst_gap1");
      step(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0, "rst_rise");
      step(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0, "rst_hold");
      gap("rst_fall");

      // Frame E: first complete frame after reset reports again
      step(1'b1, 1'b0, 8'd16, 8'd24, 8'd32, 1'b0, "fe_p0");
      gap("fe_gap0");
      gap("fe_gap1");
      step(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b1, "fe_rise");
      check_sums("fe", 28'd16, 28'd0, 28'd0, 28'd0, 28'd0, 28'd16);
      step(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0, "fe_hold");
      gap("fe_fall");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
